serial_parity_framer: RTL and testbench
=======================================

// Module: serial_parity_framer
// PURPOSE
//  Sequential stage downstream of the XOR/parity gate exercises.
//  Consumes a serial bit stream over a valid/ready handshake and XOR-accumulates
//  each frame of FRAME_LEN bits. Presents the collected frame with its parity bit
//  on a valid/ready output.
//  The next block (a parity checker/sink) consumes the frame and its parity.
// PARAMETERS
//  FRAME_LEN  8  bits per frame; legal range >= 2
//  ODD        0  0: even parity (out_parity = XOR of bits); 1: odd parity (inverted XOR)
// PORTS
//  clk         in   1                         rising-edge clock
//  rst_n       in   1                         asynchronous reset, active-low
//  clear       in   1                         synchronous abort; discards the partial or held frame
//  in_valid    in   1                         in_bit is valid
//  in_ready    out  1                         block accepts in_bit this cycle
//  in_bit      in   1                         serial data bit
//  out_valid   out  1                         out_data/out_parity are valid
//  out_ready   in   1                         consumer takes the frame this cycle
//  out_data    out  FRAME_LEN                 frame bits; first-received bit in MSB
//  out_parity  out  1                         parity of out_data per ODD
//  bit_cnt     out  $clog2(FRAME_LEN+1)       bits accepted in the current frame
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous):
//      state=COLLECT, accumulator=0, shift register=0, bit_cnt=0.
//      out_valid=0, out_data=0, out_parity=0, in_ready=1.
//  - States:
//      COLLECT: in_ready=1, out_valid=0.
//      HOLD:    in_ready=0, out_valid=1.
//  - Accept: a bit is taken only when in_valid & in_ready. On each accept:
//      acc <= acc ^ in_bit; shreg <= {shreg[FRAME_LEN-2:0], in_bit}; bit_cnt <= bit_cnt+1.
//  - Frame completion: an accept with bit_cnt==FRAME_LEN-1 moves the block to HOLD
//    on the next edge. In that edge:
//      out_data <= {shreg[FRAME_LEN-2:0], in_bit}
//      out_parity <= acc ^ in_bit ^ ODD
//      bit_cnt <= FRAME_LEN
//    Latency from the last accepted bit to out_valid is 1 cycle.
//  - HOLD: out_data, out_parity and out_valid stay stable until out_valid & out_ready.
//    - On that handshake edge: return to COLLECT; acc, shreg and bit_cnt go to 0;
//      out_valid goes to 0.
//    - out_data and out_parity keep their last values; they are don't-care while
//      out_valid=0.
//  - No input is accepted in the handshake cycle (in_ready=0 in HOLD). This gives
//    one bubble per frame, which is intentional.
//  - in_ready and out_valid are decoded from the state register only. Neither depends
//    combinationally on in_valid or out_ready.
//  - clear=1 has priority over every other event, including an accept or an output
//    handshake in the same cycle. Next state is COLLECT with acc=0, shreg=0,
//    bit_cnt=0 and out_valid=0; the held frame is dropped.
//  - in_bit is ignored whenever the handshake does not fire. X on in_bit while
//    in_valid=0 must not propagate.
//  - Reset asserted mid-frame or in HOLD: immediate return to the reset values above,
//    with no clock required.
// TESTING
//  1. FRAME_LEN=8, ODD=0; send 1,0,1,1,0,0,1,0 back-to-back with out_ready=1.
//     Expect out_valid=1 one cycle after the 8th bit, out_data=8'hB2, out_parity=0,
//     then in_ready=1 again on the next cycle.
//  2. Same bits with ODD=1: out_parity=1. Send all-ones 8'hFF: out_parity=1 (ODD=1),
//     0 (ODD=0).
//  3. Backpressure: hold out_ready=0 for 5 cycles after the frame completes.
//     out_valid, out_data and out_parity stay stable, in_ready=0, and in_valid pulses
//     are not consumed. Raising out_ready gives a single handshake.
//  4. Gaps: insert random in_valid=0 cycles with in_bit=X between bits of frame 8'h5A.
//     Result is out_data=8'h5A, out_parity=0, and bit_cnt increments only on accepts.
//  5. Pulse clear after 3 bits, then send a full frame 8'h01. Result is out_data=8'h01,
//     out_parity=1 (ODD=0). Pulse clear in HOLD: out_valid drops next cycle and no
//     handshake occurs.
//  6. Assert rst_n=0 asynchronously between clock edges mid-frame. All outputs go to
//     their reset values immediately. After release the first frame is correct.

Source files
------------

// File: rtl/serial_parity_framer.sv
// Serial-to-parallel framer: collects FRAME_LEN bits over a valid/ready input,
// then holds the frame with its even/odd parity on a valid/ready output.
module serial_parity_framer #(
   parameter int FRAME_LEN = 8,
   parameter int ODD       = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clear,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_bit,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [FRAME_LEN-1:0]             out_data,
   output logic                             out_parity,
   output logic [$clog2(FRAME_LEN+1)-1:0]   bit_cnt
);

   localparam int   CW      = $clog2(FRAME_LEN+1);
   localparam logic ODD_BIT = (ODD != 0);

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic                   acc_q, acc_d;
   logic [FRAME_LEN-2:0]   shreg_q, shreg_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [FRAME_LEN-1:0]   data_q, data_d;
   logic                   parity_q, parity_d;
   logic [FRAME_LEN-1:0]   shifted;
   logic                   accept;

   assign in_ready   = (state_q == COLLECT);
   assign out_valid  = (state_q == HOLD);
   assign out_data   = data_q;
   assign out_parity = parity_q;
   assign bit_cnt    = cnt_q;

   assign accept  = in_valid & in_ready;
   // Oldest bit ends up in the MSB once the frame is complete.
   assign shifted = {shreg_q, in_bit};

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      parity_d = parity_q;
      if (clear) begin
         state_d = COLLECT;
         acc_d   = 1'b0;
         shreg_d = '0;
         cnt_d   = '0;
      end else if (state_q == HOLD) begin
         if (out_ready) begin
            state_d = COLLECT;
            acc_d   = 1'b0;
            shreg_d = '0;
            cnt_d   = '0;
         end
      end else if (accept) begin
         acc_d   = acc_q ^ in_bit;
         shreg_d = shifted[FRAME_LEN-2:0];
         cnt_d   = cnt_q + CW'(1);
         if (cnt_q == CW'(FRAME_LEN-1)) begin
            state_d  = HOLD;
            data_d   = shifted;
            parity_d = acc_q ^ in_bit ^ ODD_BIT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= COLLECT;
         acc_q    <= 1'b0;
         shreg_q  <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         parity_q <= parity_d;
      end
   end

endmodule

// File: tb/tb_serial_parity_framer.sv
// Bench for serial_parity_framer: even and odd parity instances share stimulus and
// are compared every cycle against a queue-based frame model.
module tb_serial_parity_framer;

   localparam int N  = 8;
   localparam int CW = $clog2(N+1);

   logic clk, rst_n, clear, in_valid, in_bit, out_ready;
   logic in_ready0, out_valid0, out_parity0;
   logic in_ready1, out_valid1, out_parity1;
   logic [N-1:0]  out_data0, out_data1;
   logic [CW-1:0] bit_cnt0, bit_cnt1;

   int checks = 0;
   int errors = 0;

   bit     m_q[$];
   bit     m_hold;
   bit [N-1:0] m_data;
   bit     m_par_even;

   serial_parity_framer #(.FRAME_LEN(N), .ODD(0)) dut_even (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
      .in_bit(in_bit), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .out_parity(out_parity0), .bit_cnt(bit_cnt0));

   serial_parity_framer #(.FRAME_LEN(N), .ODD(1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
      .in_bit(in_bit), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .out_parity(out_parity1), .bit_cnt(bit_cnt1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_hold = 1'b0;
   endtask

   // One clock edge worth of the framing rules, in terms of a bit list.
   task automatic model_step();
      int ones;
      if (!rst_n) model_reset();
      else if (clear) model_reset();
      else if (m_hold) begin
         if (out_ready) model_reset();
      end else if (in_valid) begin
         m_q.push_back(in_bit);
         if (m_q.size() == N) begin
            ones = 0;
            for (int i = 0; i < N; i++) begin
               m_data[N-1-i] = m_q[i];
               ones += int'(m_q[i]);
            end
            m_par_even = bit'(ones % 2);
            m_hold     = 1'b1;
         end
      end
   endtask

   task automatic compare();
      int exp_cnt;
      exp_cnt = m_hold ? N : m_q.size();
      chk("in_ready_even", 32'(in_ready0), 32'(!m_hold));
      chk("in_ready_odd", 32'(in_ready1), 32'(!m_hold));
      chk("out_valid_even", 32'(out_valid0), 32'(m_hold));
      chk("out_valid_odd", 32'(out_valid1), 32'(m_hold));
      chk("bit_cnt_even", 32'(bit_cnt0), 32'(exp_cnt));
      chk("bit_cnt_odd", 32'(bit_cnt1), 32'(exp_cnt));
      if (m_hold) begin
         chk("out_data_even", 32'(out_data0), 32'(m_data));
         chk("out_data_odd", 32'(out_data1), 32'(m_data));
         chk("parity_even", 32'(out_parity0), 32'(m_par_even));
         chk("parity_odd", 32'(out_parity1), 32'(!m_par_even));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   // Sends a frame MSB first; gap_pct is the chance of an idle cycle before each bit.
   task automatic send_frame(input logic [N-1:0] f, input int gap_pct);
      int sent = 0;
      int budget = 200;
      while (sent < N && budget > 0) begin
         budget--;
         if ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom);
         end else begin
            in_valid = 1'b1;
            in_bit   = f[N-1-sent];
            sent++;
         end
         tick();
      end
      if (sent < N) chk("send_budget", 32'(sent), 32'(N));
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   task automatic expect_frame(input string name, input logic [N-1:0] d, input logic pe, input logic po);
      chk({name, "_valid"}, 32'(out_valid0), 32'd1);
      chk({name, "_data"}, 32'(out_data0), 32'(d));
      chk({name, "_par_even"}, 32'(out_parity0), 32'(pe));
      chk({name, "_par_odd"}, 32'(out_parity1), 32'(po));
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
      model_reset();
      repeat (3) tick();
      chk("rst_out_data", 32'(out_data0), 32'h0);
      chk("rst_out_parity", 32'(out_parity0), 32'h0);
      chk("rst_in_ready", 32'(in_ready0), 32'h1);
      rst_n = 1'b1;
      tick();

      // Back-to-back frame with immediate acceptance.
      send_frame(8'hB2, 0);
      expect_frame("b2", 8'hB2, 1'b0, 1'b1);
      tick();
      chk("b2_in_ready_after", 32'(in_ready0), 32'h1);

      send_frame(8'hFF, 0);
      expect_frame("ff", 8'hFF, 1'b0, 1'b1);
      tick();

      // Backpressure while the frame is held.
      out_ready = 1'b0;
      send_frame(8'h3C, 0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom);
         in_bit   = 1'($urandom);
         tick();
      end
      expect_frame("bp", 8'h3C, 1'b0, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_released", 32'(out_valid0), 32'h0);
      tick();
      chk("bp_single_hs", 32'(bit_cnt0), 32'h0);

      // Idle gaps inside a frame.
      send_frame(8'h5A, 40);
      expect_frame("gap", 8'h5A, 1'b0, 1'b1);
      tick();

      // Abort a partial frame, then a clean frame.
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_bit = 1'b1;
         tick();
      end
      in_valid = 1'b1; clear = 1'b1;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      chk("clr_bit_cnt", 32'(bit_cnt0), 32'h0);
      out_ready = 1'b0;
      send_frame(8'h01, 0);
      expect_frame("one", 8'h01, 1'b1, 1'b0);
      clear = 1'b1; out_ready = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_hold_valid", 32'(out_valid0), 32'h0);
      chk("clr_hold_cnt", 32'(bit_cnt0), 32'h0);
      tick();

      // Asynchronous reset between edges mid-frame.
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_bit = 1'($urandom);
         tick();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_cnt", 32'(bit_cnt0), 32'h0);
      chk("arst_in_ready", 32'(in_ready0), 32'h1);
      chk("arst_out_valid", 32'(out_valid0), 32'h0);
      chk("arst_out_data", 32'(out_data0), 32'h0);
      compare();
      tick();
      rst_n = 1'b1;
      tick();
      send_frame(8'hC7, 0);
      expect_frame("post_rst", 8'hC7, 1'b1, 1'b0);
      tick();

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(99) < 70);
         in_bit    = 1'($urandom);
         out_ready = ($urandom_range(99) < 60);
         clear     = ($urandom_range(99) < 3);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
